// File: rtl/pio_ts_pkg.sv
// Shared register offsets, channel FSM states and the INFO word packing for the PIO timestamp bank.
package pio_ts_pkg;

  localparam logic [2:0] REG_OUT       = 3'd0;
  localparam logic [2:0] REG_IN        = 3'd1;
  localparam logic [2:0] REG_EDGE_MASK = 3'd2;
  localparam logic [2:0] REG_EDGE_STAT = 3'd3;
  localparam logic [2:0] REG_TS_OUT    = 3'd4;
  localparam logic [2:0] REG_TS_IN     = 3'd5;
  localparam logic [2:0] REG_LATENCY   = 3'd6;
  localparam logic [2:0] REG_IRQ_MASK  = 3'd7;

  localparam logic [2:0] GREG_COUNT = 3'd0;
  localparam logic [2:0] GREG_CTRL  = 3'd1;
  localparam logic [2:0] GREG_INFO  = 3'd2;

  typedef enum logic [1:0] {IDLE, ARMED, DONE} ch_state_t;

  function automatic logic [31:0] info_word(input int num_ch, input int data_w,
                                            input int ts_w, input int sync_stages);
    info_word = {num_ch[7:0], data_w[7:0], ts_w[7:0], sync_stages[7:0]};
  endfunction

endpackage

// File: rtl/pio_ts_channel.sv
// One PIO channel: input synchroniser, edge detect, arm/capture FSM and its registers.
// IRQ_MASK and the DONE-entry pending flag exist only when PIO_TS_IRQ_EN is defined.
module pio_ts_channel
  import pio_ts_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int TS_W        = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [2:0]        reg_addr,
  input  logic [31:0]       wr_data,
  input  logic [TS_W-1:0]   count,
  input  logic [DATA_W-1:0] pio_in,
  output logic [DATA_W-1:0] pio_out,
  output logic [31:0]       rd_data
`ifdef PIO_TS_IRQ_EN
  ,output logic             irq_req
`endif
);

  logic [SYNC_STAGES-1:0][DATA_W-1:0] sync_q;
  logic [DATA_W-1:0] prev_q, edge_q, out_q, mask_q, stat_q, hit, clr_bits;
  logic [TS_W-1:0]   ts_out_q, ts_in_q, lat_q;
  ch_state_t         state_q, state_d;
  logic              wr_out, wr_stat, capture;

  assign wr_out   = wr_en && (reg_addr == REG_OUT);
  assign wr_stat  = wr_en && (reg_addr == REG_EDGE_STAT);
  assign clr_bits = wr_stat ? wr_data[DATA_W-1:0] : {DATA_W{1'b0}};
  assign hit      = edge_q & mask_q;
  assign pio_out  = out_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Any OUT write (re)arms, and it beats a same-cycle edge so no capture happens then.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE:    if (wr_out) state_d = ARMED;
      ARMED: begin
        if (wr_out) state_d = ARMED;
        else if (|hit) begin
          state_d = DONE;
          capture = 1'b1;
        end
      end
      DONE:    if (wr_out) state_d = ARMED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      prev_q   <= '0;
      edge_q   <= '0;
      out_q    <= '0;
      mask_q   <= '0;
      stat_q   <= '0;
      ts_out_q <= '0;
      ts_in_q  <= '0;
      lat_q    <= '0;
    end else begin
      sync_q[0] <= pio_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
      edge_q <= sync_q[SYNC_STAGES-1] ^ prev_q;
      stat_q <= (stat_q & ~clr_bits) | hit;
      if (wr_out) begin
        out_q    <= wr_data[DATA_W-1:0];
        ts_out_q <= count;
      end
      if (wr_en && (reg_addr == REG_EDGE_MASK)) mask_q <= wr_data[DATA_W-1:0];
      if (capture) begin
        ts_in_q <= count;
        lat_q   <= count - ts_out_q;
      end
    end
  end

`ifdef PIO_TS_IRQ_EN
  logic [31:0] irq_mask_q;
  logic        done_pend_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask_q  <= '0;
      done_pend_q <= 1'b0;
    end else begin
      if (wr_en && (reg_addr == REG_IRQ_MASK)) irq_mask_q <= wr_data;
      if (capture)                     done_pend_q <= 1'b1;
      else if (wr_stat && wr_data[31]) done_pend_q <= 1'b0;
    end
  end

  assign irq_req = (|(stat_q & irq_mask_q[DATA_W-1:0])) | (done_pend_q & irq_mask_q[31]);
`endif

  always_comb begin
    rd_data = '0;
    case (reg_addr)
      REG_OUT:       rd_data[DATA_W-1:0] = out_q;
      REG_IN:        rd_data[DATA_W-1:0] = sync_q[SYNC_STAGES-1];
      REG_EDGE_MASK: rd_data[DATA_W-1:0] = mask_q;
      REG_EDGE_STAT: rd_data[DATA_W-1:0] = stat_q;
      REG_TS_OUT:    rd_data[TS_W-1:0]   = ts_out_q;
      REG_TS_IN:     rd_data[TS_W-1:0]   = ts_in_q;
      REG_LATENCY:   rd_data[TS_W-1:0]   = lat_q;
`ifdef PIO_TS_IRQ_EN
      REG_IRQ_MASK:  rd_data             = irq_mask_q;
`endif
      default:       rd_data = '0;
    endcase
  end

endmodule

// File: rtl/pio_ts_bank.sv
// Bank of timestamped PIO channel pairs behind one Avalon-MM slave: shared counter, decode, read mux.
// Defining PIO_TS_IRQ_EN adds the irq port and per-channel IRQ_MASK registers.
module pio_ts_bank
  import pio_ts_pkg::*;
#(
  parameter int NUM_CH      = 16,
  parameter int DATA_W      = 32,
  parameter int TS_W        = 32,
  parameter int SYNC_STAGES = 2,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset,
  input  logic [CH_W+3:0]          avs_address,
  input  logic                     avs_read,
  input  logic                     avs_write,
  input  logic [31:0]              avs_writedata,
  output logic [31:0]              avs_readdata,
  input  logic [NUM_CH*DATA_W-1:0] pio_in_export,
  output logic [NUM_CH*DATA_W-1:0] pio_out_export
`ifdef PIO_TS_IRQ_EN
  ,output logic                    irq
`endif
);

  logic            is_global, ch_valid, count_en_q, wr_ctrl;
  logic [CH_W-1:0] ch_idx;
  logic [2:0]      reg_addr;
  logic [TS_W-1:0] count_q;
  logic [31:0]     ch_rd [NUM_CH];
  logic [31:0]     ch_rd_sel, rd_mux;

  assign is_global = avs_address[CH_W+3];
  assign ch_idx    = avs_address[CH_W+2:3];
  assign reg_addr  = avs_address[2:0];
  assign ch_valid  = !is_global && (32'(ch_idx) < NUM_CH);
  assign wr_ctrl   = avs_write && is_global && (reg_addr == GREG_CTRL);

  // A clear request wins over the increment in the same cycle.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      count_q    <= '0;
      count_en_q <= 1'b1;
    end else begin
      if (wr_ctrl) count_en_q <= avs_writedata[0];
      if (wr_ctrl && avs_writedata[1]) count_q <= '0;
      else if (count_en_q)             count_q <= count_q + TS_W'(1);
    end
  end

`ifdef PIO_TS_IRQ_EN
  logic [NUM_CH-1:0] ch_irq;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pio_ts_channel #(
      .DATA_W      (DATA_W),
      .TS_W        (TS_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk      (clk_clk),
      .reset    (reset_reset),
      .wr_en    (avs_write && ch_valid && (ch_idx == CH_W'(c))),
      .reg_addr (reg_addr),
      .wr_data  (avs_writedata),
      .count    (count_q),
      .pio_in   (pio_in_export[c*DATA_W +: DATA_W]),
      .pio_out  (pio_out_export[c*DATA_W +: DATA_W]),
      .rd_data  (ch_rd[c])
`ifdef PIO_TS_IRQ_EN
      ,.irq_req (ch_irq[c])
`endif
    );
  end

  always_comb begin
    ch_rd_sel = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (ch_valid && (ch_idx == CH_W'(c))) ch_rd_sel = ch_rd[c];
  end

  always_comb begin
    rd_mux = '0;
    if (is_global) begin
      case (reg_addr)
        GREG_COUNT: rd_mux[TS_W-1:0] = count_q;
        GREG_CTRL:  rd_mux[0]        = count_en_q;
        GREG_INFO:  rd_mux           = info_word(NUM_CH, DATA_W, TS_W, SYNC_STAGES);
        default:    rd_mux           = '0;
      endcase
    end else begin
      rd_mux = ch_rd_sel;
    end
  end

  // Sampled at the strobe edge, so a combined read+write returns the pre-write value.
  always_ff @(posedge clk_clk) begin
    if (reset_reset)   avs_readdata <= '0;
    else if (avs_read) avs_readdata <= rd_mux;
  end

`ifdef PIO_TS_IRQ_EN
  always_ff @(posedge clk_clk) begin
    if (reset_reset) irq <= 1'b0;
    else             irq <= |ch_irq;
  end
`endif

endmodule

// File: tb/tb_pio_ts_bank.sv
// Directed self-checking bench: default 16x32 bank with ch0 looped back, plus a 3x8 bank with TS_W=16 for wrap.
// IRQ checks are compiled only when PIO_TS_IRQ_EN is defined.
module tb_pio_ts_bank;
  import pio_ts_pkg::*;

  logic         clk, reset;
  logic [7:0]   m_addr;
  logic         m_read, m_write;
  logic [31:0]  m_wdata, m_rdata;
  logic [511:0] m_pio_in, m_pio_out;
  logic [511:32] m_in_hi;
  logic [5:0]   s_addr;
  logic         s_read, s_write;
  logic [31:0]  s_wdata, s_rdata;
  logic [23:0]  s_pio_in, s_pio_out;
`ifdef PIO_TS_IRQ_EN
  logic         m_irq, s_irq;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] rdata, c1, c2;

  assign m_pio_in = {m_in_hi, m_pio_out[31:0]};
  assign s_pio_in = {16'h0, s_pio_out[7:0]};

  pio_ts_bank u_main (
`ifdef PIO_TS_IRQ_EN
    .irq            (m_irq),
`endif
    .clk_clk        (clk),
    .reset_reset    (reset),
    .avs_address    (m_addr),
    .avs_read       (m_read),
    .avs_write      (m_write),
    .avs_writedata  (m_wdata),
    .avs_readdata   (m_rdata),
    .pio_in_export  (m_pio_in),
    .pio_out_export (m_pio_out)
  );

  pio_ts_bank #(.NUM_CH(3), .DATA_W(8), .TS_W(16), .SYNC_STAGES(3)) u_small (
`ifdef PIO_TS_IRQ_EN
    .irq            (s_irq),
`endif
    .clk_clk        (clk),
    .reset_reset    (reset),
    .avs_address    (s_addr),
    .avs_read       (s_read),
    .avs_write      (s_write),
    .avs_writedata  (s_wdata),
    .avs_readdata   (s_rdata),
    .pio_in_export  (s_pio_in),
    .pio_out_export (s_pio_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One bus cycle on either bank (sel=1 selects the small one); data is sampled one cycle after the strobe.
  task automatic applyStimulus(input bit sel, input bit wr, input bit rd, input bit glob,
                               input int ch, input logic [2:0] r, input logic [31:0] wdata,
                               output logic [31:0] rd_val);
    @(negedge clk);
    if (!sel) begin
      m_addr = {glob, ch[3:0], r}; m_write = wr; m_read = rd; m_wdata = wdata;
    end else begin
      s_addr = {glob, ch[1:0], r}; s_write = wr; s_read = rd; s_wdata = wdata;
    end
    @(negedge clk);
    m_write = 1'b0; m_read = 1'b0; s_write = 1'b0; s_read = 1'b0;
    rd_val = sel ? s_rdata : m_rdata;
  endtask

  task automatic bus_write(input bit sel, input bit glob, input int ch, input logic [2:0] r,
                           input logic [31:0] d);
    logic [31:0] unused_rd;
    applyStimulus(sel, 1'b1, 1'b0, glob, ch, r, d, unused_rd);
  endtask

  task automatic bus_read(input bit sel, input bit glob, input int ch, input logic [2:0] r,
                          output logic [31:0] d);
    applyStimulus(sel, 1'b0, 1'b1, glob, ch, r, 32'h0, d);
  endtask

  initial begin
    reset = 1'b1;
    m_addr = '0; m_read = 1'b0; m_write = 1'b0; m_wdata = '0; m_in_hi = '0;
    s_addr = '0; s_read = 1'b0; s_write = 1'b0; s_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Reset state, INFO, counter rate
    checkOutput("rst_readdata", m_rdata, 32'h0);
    bus_read(0, 1, 0, GREG_INFO, rdata);  checkOutput("info_main", rdata, 32'h10202002);
    bus_read(1, 1, 0, GREG_INFO, rdata);  checkOutput("info_small", rdata, 32'h03081003);
    bus_read(0, 1, 0, GREG_CTRL, rdata);  checkOutput("ctrl_rst", rdata, 32'h1);
    for (int ch = 0; ch < 16; ch += 15)
      for (int r = 0; r < 8; r++) begin
        bus_read(0, 0, ch, 3'(r), rdata);
        checkOutput($sformatf("rst_ch%0d_reg%0d", ch, r), rdata, 32'h0);
      end
    bus_read(0, 1, 0, GREG_COUNT, c1);
    repeat (2) @(posedge clk);
    bus_read(0, 1, 0, GREG_COUNT, c2);
    checkOutput("count_diff", c2 - c1, 32'd3);

    // Loopback capture on ch0 with OUT written at COUNT=100
    bus_write(0, 0, 0, REG_EDGE_MASK, 32'h1);
    bus_write(0, 1, 0, GREG_CTRL, 32'h3);
    repeat (100) @(posedge clk);
    bus_write(0, 0, 0, REG_OUT, 32'h1);
    repeat (8) @(posedge clk);
    bus_read(0, 0, 0, REG_TS_OUT, rdata);    checkOutput("ch0_ts_out", rdata, 32'd100);
    bus_read(0, 0, 0, REG_TS_IN, rdata);     checkOutput("ch0_ts_in", rdata, 32'd104);
    bus_read(0, 0, 0, REG_LATENCY, rdata);   checkOutput("ch0_latency", rdata, 32'd4);
    bus_read(0, 0, 0, REG_EDGE_STAT, rdata); checkOutput("ch0_stat", rdata, 32'h1);
    bus_read(0, 0, 0, REG_IN, rdata);        checkOutput("ch0_in", rdata, 32'h1);
    bus_read(0, 1, 0, GREG_CTRL, rdata);     checkOutput("ctrl_clear_selfclr", rdata, 32'h1);
    checkOutput("ch0_pio_out", m_pio_out[31:0], 32'h1);

    // ch3: OUT write coincides with a masked edge -> re-arm only, then a later edge captures
    bus_write(0, 0, 3, REG_EDGE_MASK, 32'h1);
    bus_write(0, 0, 3, REG_OUT, 32'h5);
    repeat (4) @(posedge clk);
    @(negedge clk) m_in_hi[96] = 1'b1;
    repeat (3) @(posedge clk);
    bus_write(0, 0, 3, REG_OUT, 32'h6);
    repeat (4) @(posedge clk);
    bus_read(0, 0, 3, REG_TS_IN, rdata);     checkOutput("ch3_collide_ts_in", rdata, 32'h0);
    bus_read(0, 0, 3, REG_LATENCY, rdata);   checkOutput("ch3_collide_lat", rdata, 32'h0);
    bus_read(0, 0, 3, REG_EDGE_STAT, rdata); checkOutput("ch3_collide_stat", rdata, 32'h1);
    bus_write(0, 0, 3, REG_OUT, 32'h7);
    m_in_hi[96] = 1'b0;
    repeat (8) @(posedge clk);
    bus_read(0, 0, 3, REG_LATENCY, rdata);   checkOutput("ch3_rearm_lat", rdata, 32'd4);
    bus_read(0, 0, 3, REG_OUT, rdata);       checkOutput("ch3_out", rdata, 32'h7);

    // EDGE_STAT w1c, set-vs-clear collision, unmasked bit
    bus_write(0, 0, 3, REG_EDGE_STAT, 32'h1);
    bus_read(0, 0, 3, REG_EDGE_STAT, rdata); checkOutput("ch3_w1c", rdata, 32'h0);
    @(negedge clk) m_in_hi[96] = 1'b1;
    repeat (3) @(posedge clk);
    bus_write(0, 0, 3, REG_EDGE_STAT, 32'h1);
    bus_read(0, 0, 3, REG_EDGE_STAT, rdata); checkOutput("ch3_w1c_vs_set", rdata, 32'h1);
    bus_write(0, 0, 3, REG_EDGE_STAT, 32'h1);
    @(negedge clk) m_in_hi[97] = 1'b1;
    repeat (6) @(posedge clk);
    bus_read(0, 0, 3, REG_EDGE_STAT, rdata); checkOutput("ch3_unmasked", rdata, 32'h0);
    bus_read(0, 0, 3, REG_IN, rdata);        checkOutput("ch3_in", rdata, 32'h3);

    // Read+write in one cycle returns the old value; unmapped global reads 0
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 1, REG_OUT, 32'hAA, rdata);
    checkOutput("rw_pre_value", rdata, 32'h0);
    bus_read(0, 0, 1, REG_OUT, rdata);       checkOutput("rw_post_value", rdata, 32'hAA);
    checkOutput("ch1_pio_out", m_pio_out[63:32], 32'hAA);
    bus_write(0, 1, 0, 3'd5, 32'hFFFF_FFFF);
    bus_read(0, 1, 0, 3'd5, rdata);          checkOutput("unmapped_global", rdata, 32'h0);

    // Small bank: ch == NUM_CH is dead, 16-bit wrap of the latency
    bus_write(1, 0, 3, REG_OUT, 32'hFF);
    bus_read(1, 0, 3, REG_OUT, rdata);       checkOutput("ch_out_of_range", rdata, 32'h0);
    bus_read(1, 0, 2, REG_OUT, rdata);       checkOutput("ch2_no_alias", rdata, 32'h0);
    bus_write(1, 0, 0, REG_EDGE_MASK, 32'h1);
    bus_write(1, 1, 0, GREG_CTRL, 32'h3);
    repeat (16'hFFFE) @(posedge clk);
    bus_write(1, 0, 0, REG_OUT, 32'h1);
    repeat (10) @(posedge clk);
    bus_read(1, 0, 0, REG_TS_OUT, rdata);    checkOutput("wrap_ts_out", rdata, 32'h0000FFFE);
    bus_read(1, 0, 0, REG_TS_IN, rdata);     checkOutput("wrap_ts_in", rdata, 32'h00000003);
    bus_read(1, 0, 0, REG_LATENCY, rdata);   checkOutput("wrap_latency", rdata, 32'd5);

    // Reset while ch0 is armed: everything back to zero and IDLE
    bus_write(0, 0, 0, REG_OUT, 32'h0);
    m_in_hi = '0;
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    repeat (8) @(posedge clk);
    bus_read(0, 0, 0, REG_TS_IN, rdata);     checkOutput("mid_rst_ts_in", rdata, 32'h0);
    bus_read(0, 0, 0, REG_TS_OUT, rdata);    checkOutput("mid_rst_ts_out", rdata, 32'h0);
    bus_read(0, 0, 0, REG_LATENCY, rdata);   checkOutput("mid_rst_lat", rdata, 32'h0);
    bus_read(0, 0, 3, REG_EDGE_MASK, rdata); checkOutput("mid_rst_mask", rdata, 32'h0);
    bus_write(0, 0, 3, REG_EDGE_MASK, 32'h1);
    @(negedge clk) m_in_hi[96] = 1'b1;
    repeat (6) @(posedge clk);
    bus_read(0, 0, 3, REG_EDGE_STAT, rdata); checkOutput("idle_edge_stat", rdata, 32'h1);
    bus_read(0, 0, 3, REG_TS_IN, rdata);     checkOutput("idle_no_capture", rdata, 32'h0);

`ifdef PIO_TS_IRQ_EN
    checkOutput("irq_rst", {31'b0, m_irq}, 32'h0);
    bus_write(0, 0, 0, REG_IRQ_MASK, 32'h8000_0000);
    bus_read(0, 0, 0, REG_IRQ_MASK, rdata);  checkOutput("irq_mask_rd", rdata, 32'h8000_0000);
    bus_write(0, 0, 0, REG_EDGE_MASK, 32'h1);
    bus_write(0, 0, 0, REG_OUT, 32'h1);
    repeat (4) @(posedge clk);
    @(negedge clk) checkOutput("irq_before", {31'b0, m_irq}, 32'h0);
    @(negedge clk) checkOutput("irq_after_capture", {31'b0, m_irq}, 32'h1);
    bus_write(0, 0, 0, REG_EDGE_STAT, 32'h8000_0000);
    repeat (2) @(posedge clk);
    @(negedge clk) checkOutput("irq_w1c", {31'b0, m_irq}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
